mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage of the 5-stage pipeline, sitting between EX/MEM and the write-back stage.
- Drives the data-RAM port: word-aligned address, byte strobes, lane-shifted store data, request/ready handshake.
- Stalls the pipeline while RAM is slow and holds the MEM/WB pipeline register.
- The register feeds write-back, which does lane extraction and sign extension using result[1:0] and mem_sel.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in BUSY without ram_ready before abort; 0 disables timeout.
CNT_WIDTH, 5, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  discard the instruction in this stage (branch/exception).
valid_in  in  1  EX/MEM holds a valid instruction.
result_in  in  32  ALU result; effective address for load/store.
store_data_in  in  32  rs2 value for stores (unshifted).
mem_read_flag_in  in  1  load.
mem_write_flag_in  in  1  store.
mem_sign_flag_in  in  1  signed load.
mem_sel_in  in  4  0001 byte, 0011 half, 1111 word; any other value is illegal.
reg_write_en_in  in  1  destination write enable.
reg_write_addr_in  in  5  destination register.
current_pc_addr_in  in  32  PC of the instruction.
ram_en  out  1  RAM request.
ram_write_en  out  4  byte strobes; 0000 on loads.
ram_addr  out  32  {result_in[31:2],2'b00}.
ram_write_data  out  32  store data shifted to its byte lane.
ram_ready  in  1  RAM accepts/returns in the cycle sampled high.
ram_read_data  in  32  valid when ram_ready=1 on a load.
stall_req  out  1  hold PC/IF/ID/EX/MEM this cycle.
bus_error  out  1  one-cycle pulse: timeout or misaligned access.
wb_*  out  —  registered copies for write-back: result(32), reg_write_en(1), reg_write_addr(5), mem_read_flag(1), mem_write_flag(1), mem_sign_flag(1), mem_sel(4), ram_read_data(32), current_pc_addr(32).

Behaviour:
- Reset: state=IDLE; counter=0; all wb_* = 0; bus_error=0.
- Combinational outputs are 0 when not requesting: ram_en, ram_write_en, ram_write_data, stall_req.
- mem_op = valid_in & (mem_read_flag_in | mem_write_flag_in).
- Byte strobes: strb = mem_sel_in << result_in[1:0], truncated to 4 bits.
- Store data lane shift: store_data_in << (8*result_in[1:0]).
- IDLE, mem_op=1:
  - ram_en=1 combinationally; ram_write_en = strb on stores, 0000 on loads.
  - ram_ready=1: zero-wait access; no stall; MEM/WB captures at the edge; wb_ram_data = ram_read_data.
  - ram_ready=0: stall_req=1; next state BUSY; counter=1.
- BUSY:
  - ram_en, ram_addr, ram_write_en and ram_write_data stay asserted and stable (upstream is stalled, so inputs are unchanged).
  - stall_req = ~ram_ready.
  - ram_ready=1: capture into MEM/WB; go to IDLE.
  - Otherwise counter increments.
  - counter==TIMEOUT_CYCLES (nonzero): ram_en drops; bubble captured (wb_reg_write_en=0, wb mem flags=0); bus_error=1 next cycle; go to IDLE; stall released.
- Non-memory instruction (valid_in=1, mem_op=0): one-cycle pass-through into MEM/WB; wb_ram_read_data=0.
- valid_in=0: bubble; every wb_* is 0.
- Stall cycles: MEM/WB is loaded with a bubble (wb_reg_write_en=0, flags 0), so the stalled instruction writes back exactly once.
- flush in IDLE:
  - No RAM request is issued.
  - Bubble captured.
- flush in BUSY:
  - The bus transaction is not aborted; it runs to ready or timeout (stores still complete).
  - A sticky kill bit forces the completion capture to be a bubble.
  - The kill bit clears on return to IDLE.
- rst mid-BUSY: immediate IDLE; ram_en=0 in the following cycle; no capture.
- Load/store both set: treat as store.
- Illegal mem_sel: no request; bubble; bus_error pulse.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Half access with result_in[0]=1, or word access with result_in[1:0]≠0, issues no RAM request.
  - Captures a bubble and pulses bus_error the next cycle.
- Undefined:
  - Misaligned accesses proceed with truncated strobes.
  - Write-back returns 0 for misaligned loads.
  - bus_error fires only on timeout or illegal mem_sel.

Test Plan:
- LW from 0x100, ram_ready tied 1, ram_read_data=0xDEADBEEF -> ram_addr=0x100, no stall; next cycle wb_ram_read_data=0xDEADBEEF, wb_reg_write_en=1.
- SB 0xA5 to 0x203, ready after 3 cycles -> ram_write_en=1000, ram_write_data=0xA5000000 held stable; stall_req high 3 cycles; exactly one wb capture.
- SH 0x1234 to 0x302 -> ram_write_en=1100, ram_write_data=0x12340000, ram_addr=0x300.
- Load, ram_ready never asserted, TIMEOUT_CYCLES=4 -> stall 4 cycles, ram_en drops, bus_error 1-cycle pulse, wb_reg_write_en=0.
- Load in BUSY, flush asserted, ready 2 cycles later -> ram_en held until ready; wb_reg_write_en=0; stall released.
- With MEM_ALIGN_CHECK_EN, LW at 0x102 -> ram_en never 1, bus_error pulse; without it -> request with ram_addr=0x100, ram_write_en=0000.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if
//
// Data-RAM port used by the memory-access stage of the pipeline.
//
// Signals:
//   ram_en          request to the RAM (stage -> RAM)
//   ram_write_en    byte strobes, 0000 for loads (stage -> RAM)
//   ram_addr        word-aligned address (stage -> RAM)
//   ram_write_data  store data already shifted into its byte lane (stage -> RAM)
//   ram_ready       RAM accepts/returns in the cycle it is sampled high (RAM -> stage)
//   ram_read_data   load data, valid while ram_ready=1 (RAM -> stage)
//
// Modports:
//   master  the pipeline stage issuing requests
//   slave   the RAM answering them
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        ram_ready;
    logic [31:0] ram_read_data;

    modport master (
        output ram_en,
        output ram_write_en,
        output ram_addr,
        output ram_write_data,
        input  ram_ready,
        input  ram_read_data
    );

    modport slave (
        input  ram_en,
        input  ram_write_en,
        input  ram_addr,
        input  ram_write_data,
        output ram_ready,
        output ram_read_data
    );
endinterface

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the 5-stage pipeline, between EX/MEM and write-back.
// Issues loads/stores on the data-RAM port, stalls the front of the pipeline
// while the RAM is slow, and holds the MEM/WB pipeline register. Write-back
// does lane extraction and sign extension from wb_result[1:0] and wb_mem_sel.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles in BUSY without ram_ready before the access is
//                   abandoned; 0 disables the timeout
//   CNT_WIDTH       width of the wait counter, must hold TIMEOUT_CYCLES
//
// Optional feature (compile-time macro MEM_ALIGN_CHECK_EN):
//   defined    misaligned half/word accesses issue no request, capture a
//              bubble and pulse bus_error
//   undefined  misaligned accesses go out with truncated strobes and a
//              misaligned load writes back 0
//
// Ports:
//   clk, rst                synchronous active-high reset
//   flush                   discard the instruction held in this stage
//   valid_in .. current_pc_addr_in   EX/MEM pipeline register contents
//   ram                     data-RAM port (master side)
//   stall_req               hold PC/IF/ID/EX/MEM this cycle
//   bus_error               one-cycle pulse on timeout, illegal mem_sel or
//                           (with MEM_ALIGN_CHECK_EN) misalignment
//   wb_*                    MEM/WB pipeline register outputs
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                valid_in,
    input  logic [31:0]         result_in,
    input  logic [31:0]         store_data_in,
    input  logic                mem_read_flag_in,
    input  logic                mem_write_flag_in,
    input  logic                mem_sign_flag_in,
    input  logic [3:0]          mem_sel_in,
    input  logic                reg_write_en_in,
    input  logic [4:0]          reg_write_addr_in,
    input  logic [31:0]         current_pc_addr_in,
    mem_access_stage_if.master  ram,
    output logic                stall_req,
    output logic                bus_error,
    output logic [31:0]         wb_result,
    output logic                wb_reg_write_en,
    output logic [4:0]          wb_reg_write_addr,
    output logic                wb_mem_read_flag,
    output logic                wb_mem_write_flag,
    output logic                wb_mem_sign_flag,
    output logic [3:0]          wb_mem_sel,
    output logic [31:0]         wb_ram_read_data,
    output logic [31:0]         wb_current_pc_addr
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic                 TIMEOUT_ON  = (TIMEOUT_CYCLES != 0);

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic [CNT_WIDTH-1:0] wait_cnt_next;
    logic                 kill;
    logic                 kill_next;
    logic                 err_next;
    logic                 capture;
    logic                 ram_req;

    logic                 is_store;
    logic                 is_load;
    logic                 mem_op;
    logic                 sel_legal;
    logic                 misaligned;
    logic                 align_fault;
    logic                 access_fault;
    logic [3:0]           strb;
    logic [31:0]          lane_data;
    logic [31:0]          capture_rdata;

    // A store wins when both flags are set, so a load is only a pure read.
    assign is_store  = mem_write_flag_in;
    assign is_load   = mem_read_flag_in & ~mem_write_flag_in;
    assign mem_op    = valid_in & (mem_read_flag_in | mem_write_flag_in);

    assign sel_legal  = (mem_sel_in == 4'b0001) || (mem_sel_in == 4'b0011) ||
                        (mem_sel_in == 4'b1111);
    assign misaligned = ((mem_sel_in == 4'b0011) && result_in[0]) ||
                        ((mem_sel_in == 4'b1111) && (result_in[1:0] != 2'b00));

`ifdef MEM_ALIGN_CHECK_EN
    assign align_fault = misaligned;
`else
    assign align_fault = 1'b0;
`endif

    assign access_fault = ~sel_legal | align_fault;

    // Strobes and data move into the lane selected by the low address bits;
    // strobes that fall off the top of the word are simply lost.
    assign strb      = mem_sel_in << result_in[1:0];
    assign lane_data = store_data_in << {result_in[1:0], 3'b000};

    // Misaligned loads (only reachable with the alignment check off) return 0.
    assign capture_rdata = (is_load && !misaligned) ? ram.ram_read_data : 32'h0;

    assign ram.ram_addr       = {result_in[31:2], 2'b00};
    assign ram.ram_en         = ram_req;
    assign ram.ram_write_en   = (ram_req && is_store) ? strb : 4'b0000;
    assign ram.ram_write_data = (ram_req && is_store) ? lane_data : 32'h0;

    // Next-state and request/stall decode. Upstream is frozen while BUSY, so
    // the EX/MEM inputs still describe the in-flight access.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        kill_next     = kill;
        err_next      = 1'b0;
        capture       = 1'b0;
        ram_req       = 1'b0;
        stall_req     = 1'b0;

        case (state)
            IDLE: begin
                wait_cnt_next = '0;
                kill_next     = 1'b0;
                if (flush || !valid_in) begin
                    capture = 1'b0;
                end else if (!mem_op) begin
                    capture = 1'b1;
                end else if (access_fault) begin
                    err_next = 1'b1;
                end else begin
                    ram_req = 1'b1;
                    if (ram.ram_ready) begin
                        capture = 1'b1;
                    end else begin
                        stall_req     = 1'b1;
                        state_next    = BUSY;
                        wait_cnt_next = CNT_WIDTH'(1);
                    end
                end
            end

            BUSY: begin
                if (flush) begin
                    kill_next = 1'b1;
                end
                if (ram.ram_ready) begin
                    // A flush seen during the wait turns the completion into a
                    // bubble, but the bus transfer itself still finishes.
                    ram_req       = 1'b1;
                    capture       = ~(kill | flush);
                    state_next    = IDLE;
                    kill_next     = 1'b0;
                    wait_cnt_next = '0;
                end else if (TIMEOUT_ON && (wait_cnt == TIMEOUT_VAL)) begin
                    err_next      = 1'b1;
                    state_next    = IDLE;
                    kill_next     = 1'b0;
                    wait_cnt_next = '0;
                end else begin
                    ram_req   = 1'b1;
                    stall_req = 1'b1;
                    if (wait_cnt != {CNT_WIDTH{1'b1}}) begin
                        wait_cnt_next = wait_cnt + CNT_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state: FSM, wait counter, flush kill bit and the error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            kill      <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            kill      <= kill_next;
            bus_error <= err_next;
        end
    end

    // MEM/WB register: every cycle either takes the instruction or a bubble,
    // so a stalled instruction reaches write-back exactly once.
    always_ff @(posedge clk) begin
        if (rst || !capture) begin
            wb_result          <= 32'h0;
            wb_reg_write_en    <= 1'b0;
            wb_reg_write_addr  <= 5'h0;
            wb_mem_read_flag   <= 1'b0;
            wb_mem_write_flag  <= 1'b0;
            wb_mem_sign_flag   <= 1'b0;
            wb_mem_sel         <= 4'h0;
            wb_ram_read_data   <= 32'h0;
            wb_current_pc_addr <= 32'h0;
        end else begin
            wb_result          <= result_in;
            wb_reg_write_en    <= reg_write_en_in;
            wb_reg_write_addr  <= reg_write_addr_in;
            wb_mem_read_flag   <= is_load;
            wb_mem_write_flag  <= is_store;
            wb_mem_sign_flag   <= mem_sign_flag_in;
            wb_mem_sel         <= mem_sel_in;
            wb_ram_read_data   <= capture_rdata;
            wb_current_pc_addr <= current_pc_addr_in;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Self-checking bench for mem_access_stage (built with TIMEOUT_CYCLES=4).
// Each transaction pushes its expected MEM/WB contents into a scoreboard;
// a negedge monitor pops and compares whenever a non-bubble reaches wb_*.
// Honours MEM_ALIGN_CHECK_EN for the misaligned-load case.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int TIMEOUT = 4;

    typedef struct {
        logic [31:0] result;
        logic        rwe;
        logic [4:0]  rwa;
        logic        rd;
        logic        wr;
        logic        sgn;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic [31:0] pc;
    } wb_rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid_in;
    logic [31:0] result_in;
    logic [31:0] store_data_in;
    logic        mem_read_flag_in;
    logic        mem_write_flag_in;
    logic        mem_sign_flag_in;
    logic [3:0]  mem_sel_in;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] current_pc_addr_in;
    logic        stall_req;
    logic        bus_error;
    logic [31:0] wb_result;
    logic        wb_reg_write_en;
    logic [4:0]  wb_reg_write_addr;
    logic        wb_mem_read_flag;
    logic        wb_mem_write_flag;
    logic        wb_mem_sign_flag;
    logic [3:0]  wb_mem_sel;
    logic [31:0] wb_ram_read_data;
    logic [31:0] wb_current_pc_addr;

    int      check_count = 0;
    int      error_count = 0;
    wb_rec_t sb_queue[$];
    wb_rec_t mon_rec;

    mem_access_stage_if ram_bus ();

    mem_access_stage #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_WIDTH      (5)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .valid_in           (valid_in),
        .result_in          (result_in),
        .store_data_in      (store_data_in),
        .mem_read_flag_in   (mem_read_flag_in),
        .mem_write_flag_in  (mem_write_flag_in),
        .mem_sign_flag_in   (mem_sign_flag_in),
        .mem_sel_in         (mem_sel_in),
        .reg_write_en_in    (reg_write_en_in),
        .reg_write_addr_in  (reg_write_addr_in),
        .current_pc_addr_in (current_pc_addr_in),
        .ram                (ram_bus.master),
        .stall_req          (stall_req),
        .bus_error          (bus_error),
        .wb_result          (wb_result),
        .wb_reg_write_en    (wb_reg_write_en),
        .wb_reg_write_addr  (wb_reg_write_addr),
        .wb_mem_read_flag   (wb_mem_read_flag),
        .wb_mem_write_flag  (wb_mem_write_flag),
        .wb_mem_sign_flag   (wb_mem_sign_flag),
        .wb_mem_sel         (wb_mem_sel),
        .wb_ram_read_data   (wb_ram_read_data),
        .wb_current_pc_addr (wb_current_pc_addr)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives one instruction, plays the RAM (ready after ready_delay cycles,
    // -1 = never), optionally flushes in cycle flush_at, and checks the
    // request/stall timeline cycle by cycle plus the bus_error pulse.
    task automatic applyStimulus(
        input string       tag,
        input logic [31:0] pc,
        input logic [31:0] res,
        input logic [31:0] sdata,
        input logic        rd,
        input logic        wr,
        input logic        sgn,
        input logic [3:0]  sel,
        input logic        rwe,
        input logic [4:0]  rwa,
        input int          ready_delay,
        input int          flush_at,
        input logic [31:0] rdata,
        input logic        exp_req,
        input logic [3:0]  exp_strb,
        input logic [31:0] exp_wdata,
        input int          exp_stalls,
        input logic        exp_err,
        input logic        exp_capture,
        input logic [31:0] exp_rdata
    );
        wb_rec_t rec;
        logic    en_exp;
        @(posedge clk);
        #1;
        valid_in           = 1'b1;
        result_in          = res;
        store_data_in      = sdata;
        mem_read_flag_in   = rd;
        mem_write_flag_in  = wr;
        mem_sign_flag_in   = sgn;
        mem_sel_in         = sel;
        reg_write_en_in    = rwe;
        reg_write_addr_in  = rwa;
        current_pc_addr_in = pc;
        if (exp_capture) begin
            rec.result = res;
            rec.rwe    = rwe;
            rec.rwa    = rwa;
            rec.rd     = rd & ~wr;
            rec.wr     = wr;
            rec.sgn    = sgn;
            rec.sel    = sel;
            rec.rdata  = exp_rdata;
            rec.pc     = pc;
            sb_queue.push_back(rec);
        end
        for (int c = 0; c <= exp_stalls; c++) begin
            flush                 = (c == flush_at);
            ram_bus.ram_ready     = (c == ready_delay);
            ram_bus.ram_read_data = (c == ready_delay) ? rdata : 32'h0;
            @(negedge clk);
            en_exp = exp_req && ((c < exp_stalls) || (c == ready_delay));
            checkOutput({tag, ".stall"}, 32'(stall_req), 32'(c < exp_stalls));
            checkOutput({tag, ".ram_en"}, 32'(ram_bus.ram_en), 32'(en_exp));
            if (en_exp) begin
                checkOutput({tag, ".addr"}, ram_bus.ram_addr, {res[31:2], 2'b00});
                checkOutput({tag, ".strb"}, 32'(ram_bus.ram_write_en), 32'(exp_strb));
                if (wr) begin
                    checkOutput({tag, ".wdata"}, ram_bus.ram_write_data, exp_wdata);
                end
            end
            @(posedge clk);
            #1;
        end
        valid_in              = 1'b0;
        flush                 = 1'b0;
        ram_bus.ram_ready     = 1'b0;
        ram_bus.ram_read_data = 32'h0;
        @(negedge clk);
        checkOutput({tag, ".bus_error"}, 32'(bus_error), 32'(exp_err));
        checkOutput({tag, ".idle_en"}, 32'(ram_bus.ram_en), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput({tag, ".err_pulse"}, 32'(bus_error), 32'h0);
    endtask

    // Scoreboard monitor: any non-bubble MEM/WB content must match the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && ((wb_current_pc_addr != 32'h0) || (wb_result != 32'h0) ||
                     wb_reg_write_en || wb_mem_read_flag || wb_mem_write_flag)) begin
            if (sb_queue.size() == 0) begin
                checkOutput("sb.unexpected_pc", wb_current_pc_addr, 32'h0);
            end else begin
                mon_rec = sb_queue.pop_front();
                checkOutput("wb.result", wb_result, mon_rec.result);
                checkOutput("wb.reg_write_en", 32'(wb_reg_write_en), 32'(mon_rec.rwe));
                checkOutput("wb.reg_write_addr", 32'(wb_reg_write_addr), 32'(mon_rec.rwa));
                checkOutput("wb.mem_read", 32'(wb_mem_read_flag), 32'(mon_rec.rd));
                checkOutput("wb.mem_write", 32'(wb_mem_write_flag), 32'(mon_rec.wr));
                checkOutput("wb.mem_sign", 32'(wb_mem_sign_flag), 32'(mon_rec.sgn));
                checkOutput("wb.mem_sel", 32'(wb_mem_sel), 32'(mon_rec.sel));
                checkOutput("wb.ram_read_data", wb_ram_read_data, mon_rec.rdata);
                checkOutput("wb.pc", wb_current_pc_addr, mon_rec.pc);
            end
        end
    end

    // Hard stop in case the stimulus ever stops advancing.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus sequence.
    initial begin
        rst                   = 1'b1;
        flush                 = 1'b0;
        valid_in              = 1'b1;
        result_in             = 32'h99;
        store_data_in         = 32'h0;
        mem_read_flag_in      = 1'b0;
        mem_write_flag_in     = 1'b0;
        mem_sign_flag_in      = 1'b0;
        mem_sel_in            = 4'b1111;
        reg_write_en_in       = 1'b1;
        reg_write_addr_in     = 5'd1;
        current_pc_addr_in    = 32'h99;
        ram_bus.ram_ready     = 1'b0;
        ram_bus.ram_read_data = 32'h0;

        // Reset holds MEM/WB empty even with a valid instruction presented.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.wb_result", wb_result, 32'h0);
        checkOutput("reset.wb_reg_write_en", 32'(wb_reg_write_en), 32'h0);
        checkOutput("reset.wb_pc", wb_current_pc_addr, 32'h0);
        checkOutput("reset.bus_error", 32'(bus_error), 32'h0);
        checkOutput("reset.stall", 32'(stall_req), 32'h0);
        checkOutput("reset.ram_en", 32'(ram_bus.ram_en), 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;

        //            tag         pc            res           sdata         rd    wr    sgn   sel      rwe   rwa   rdy  fl  rdata         req   strb     wdata         stl err   cap   exp_rdata
        applyStimulus("lw_fast",  32'h1000, 32'h100, 32'h0,        1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 5'd3, 0,  -1, 32'hDEADBEEF, 1'b1, 4'b0000, 32'h0,        0, 1'b0, 1'b1, 32'hDEADBEEF);
        applyStimulus("sb_slow",  32'h1004, 32'h203, 32'hFFFFFFA5, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 5'd0, 3,  -1, 32'h0,        1'b1, 4'b1000, 32'hA5000000, 3, 1'b0, 1'b1, 32'h0);
        applyStimulus("sh",       32'h1008, 32'h302, 32'h00001234, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 5'd0, 1,  -1, 32'h0,        1'b1, 4'b1100, 32'h12340000, 1, 1'b0, 1'b1, 32'h0);
        applyStimulus("lw_tmo",   32'h100C, 32'h400, 32'h0,        1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 5'd4, -1, -1, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 1'b1, 1'b0, 32'h0);
        applyStimulus("lw_flush", 32'h1010, 32'h500, 32'h0,        1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 5'd5, 3,  1,  32'h12345678, 1'b1, 4'b0000, 32'h0,        3, 1'b0, 1'b0, 32'h0);
        applyStimulus("lb_sgn",   32'h1014, 32'h701, 32'h0,        1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 5'd6, 2,  -1, 32'h0000AB00, 1'b1, 4'b0000, 32'h0,        2, 1'b0, 1'b1, 32'h0000AB00);
        applyStimulus("rd_wr",    32'h1018, 32'h600, 32'h89ABCDEF, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 5'd0, 0,  -1, 32'h0,        1'b1, 4'b1111, 32'h89ABCDEF, 0, 1'b0, 1'b1, 32'h0);
        applyStimulus("bad_sel",  32'h101C, 32'h900, 32'h11223344, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b0, 5'd0, 0,  -1, 32'h0,        1'b0, 4'b0000, 32'h0,        0, 1'b1, 1'b0, 32'h0);
        applyStimulus("flush_id", 32'h1020, 32'hA00, 32'h0,        1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 5'd7, 0,  0,  32'h0,        1'b0, 4'b0000, 32'h0,        0, 1'b0, 1'b0, 32'h0);
        applyStimulus("alu",      32'h1024, 32'h77,  32'h0,        1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 5'd8, 0,  -1, 32'h55,       1'b0, 4'b0000, 32'h0,        0, 1'b0, 1'b1, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        applyStimulus("lw_misal", 32'h1028, 32'h102, 32'h0,        1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 5'd9, 0,  -1, 32'hCAFEF00D, 1'b0, 4'b0000, 32'h0,        0, 1'b1, 1'b0, 32'h0);
`else
        applyStimulus("lw_misal", 32'h1028, 32'h102, 32'h0,        1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 5'd9, 0,  -1, 32'hCAFEF00D, 1'b1, 4'b0000, 32'h0,        0, 1'b0, 1'b1, 32'h0);
`endif

        // Reset in the middle of a wait: back to IDLE, no capture, no error.
        @(posedge clk);
        #1;
        valid_in           = 1'b1;
        result_in          = 32'h800;
        mem_read_flag_in   = 1'b1;
        mem_write_flag_in  = 1'b0;
        mem_sel_in         = 4'b1111;
        reg_write_en_in    = 1'b1;
        reg_write_addr_in  = 5'd10;
        current_pc_addr_in = 32'h2000;
        ram_bus.ram_ready  = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy.stall_idle", 32'(stall_req), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_busy.en_busy", 32'(ram_bus.ram_en), 32'h1);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy.en_after", 32'(ram_bus.ram_en), 32'h0);
        checkOutput("rst_busy.stall_after", 32'(stall_req), 32'h0);
        for (int i = 0; i < TIMEOUT + 2; i++) begin
            @(negedge clk);
            checkOutput("rst_busy.no_error", 32'(bus_error), 32'h0);
        end

        applyStimulus("lw_after", 32'h3000, 32'h104, 32'h0,        1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 5'd11, 0, -1, 32'h0BADF00D, 1'b1, 4'b0000, 32'h0,        0, 1'b0, 1'b1, 32'h0BADF00D);

        repeat (2) @(negedge clk);
        checkOutput("sb.drained", 32'(sb_queue.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
